// File: rtl/dmem_responder.sv
// Data-side memory responder: byte-lane RAM with combinational load path plus an MMIO
// window holding a console TX FIFO and a free-running cycle counter. Optional macro: DMEM_BACKDOOR_EN.
module dmem_responder #(
  parameter int          MEM_WORDS  = 4096,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_write,
  input  logic        i_load,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_memsize,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
`ifdef DMEM_BACKDOOR_EN
  ,
  input  logic                          i_bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0]  i_bd_addr,
  input  logic [31:0]                   i_bd_data
`endif
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLE  = 2'd2;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

  // ---------------------------------------------------------------- decode
  logic [31:0]   offset;
  logic          is_mmio;
  logic [1:0]    reg_sel;
  logic [1:0]    byte_off;
  logic [AW-1:0] ram_idx;
  logic [1:0]    ld_size;
  logic          st_en;
  logic          st_mis;
  logic          st_ok;
  logic          ld_mis;

  assign offset   = i_addr - MMIO_BASE;
  assign is_mmio  = (offset < 32'd16);
  assign reg_sel  = offset[3:2];
  assign byte_off = i_addr[1:0];
  assign ram_idx  = i_addr[AW+1:2];

  // Size 00 means "no store" on the write side but a full word on the load side.
  assign ld_size = (i_memsize == 2'b00) ? SZ_WORD : i_memsize;
  assign st_en   = i_write && (i_memsize != 2'b00);
  assign st_mis  = st_en && misaligned(i_memsize, byte_off);
  assign st_ok   = st_en && !st_mis;
  assign ld_mis  = i_load && misaligned(ld_size, byte_off);

  // ---------------------------------------------------------------- RAM
  logic [3:0]  lane_en;
  logic [31:0] st_data;
  logic        ram_we;
  logic [31:0] ram_word;

  always_comb begin
    lane_en = 4'b0000;
    case (i_memsize)
      SZ_BYTE: lane_en = 4'b0001 << byte_off;
      SZ_HALF: lane_en = 4'b0011 << byte_off;
      SZ_WORD: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  assign st_data = i_wdata << {byte_off, 3'b000};
  assign ram_we  = st_ok && !is_mmio;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [MEM_WORDS];

    assign ram_word[8*gi +: 8] = lane_mem[ram_idx];

    always_ff @(posedge i_clk) begin
`ifdef DMEM_BACKDOOR_EN
      if (i_bd_we) begin
        lane_mem[i_bd_addr] <= i_bd_data[8*gi +: 8];
      end
      if (ram_we && lane_en[gi] && !(i_bd_we && (i_bd_addr == ram_idx))) begin
        lane_mem[ram_idx] <= st_data[8*gi +: 8];
      end
`else
      if (ram_we && lane_en[gi]) begin
        lane_mem[ram_idx] <= st_data[8*gi +: 8];
      end
`endif
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr_reg;
  logic [FW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          ovf_reg;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          push_acc;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(FIFO_DEPTH));
  assign push     = st_ok && is_mmio && (reg_sel == REG_TXDATA);
  assign pop      = !empty && i_tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_acc = push && (!full || pop);

  always_comb begin
    count_next = count_reg;
    case ({push_acc, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_acc) begin
      fifo_mem[wr_ptr_reg] <= i_wdata[7:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (push && full && !pop) ovf_reg <= 1'b1;
    end
  end

  assign o_tx_valid = !empty;
  assign o_tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr_reg];

  // ---------------------------------------------------------------- cycle counter and flags
  logic [31:0] cycle_reg;
  logic        misalign_reg;
  logic        cycle_clr;
  logic        misalign_set;

  assign cycle_clr    = st_ok && is_mmio && (reg_sel == REG_CYCLE);
  // A combined write+load is a store, so only the store side can flag it.
  assign misalign_set = st_mis || (ld_mis && !i_write);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_reg    <= '0;
      misalign_reg <= 1'b0;
    end else begin
      cycle_reg <= cycle_clr ? 32'd0 : cycle_reg + 32'd1;
      if (misalign_set) misalign_reg <= 1'b1;
    end
  end

  assign o_misalign = misalign_reg;

  // ---------------------------------------------------------------- load path
  logic [31:0] status_word;
  logic [31:0] mmio_rdata;
  logic [31:0] ram_shift;
  logic [31:0] ram_rdata;

  assign status_word = {16'h0000, 8'(count_reg), 5'b00000, ovf_reg, full, empty};

  always_comb begin
    mmio_rdata = 32'd0;
    case (reg_sel)
      REG_STATUS: mmio_rdata = status_word;
      REG_CYCLE:  mmio_rdata = cycle_reg;
      default:    mmio_rdata = 32'd0;
    endcase
  end

  assign ram_shift = ram_word >> {byte_off, 3'b000};

  always_comb begin
    ram_rdata = ram_shift;
    case (ld_size)
      SZ_BYTE: ram_rdata = {24'h000000, ram_shift[7:0]};
      SZ_HALF: ram_rdata = {16'h0000, ram_shift[15:0]};
      default: ram_rdata = ram_shift;
    endcase
  end

  always_comb begin
    o_rdata = 32'd0;
    if (i_load && !ld_mis) begin
      o_rdata = is_mmio ? mmio_rdata : ram_rdata;
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-side memory responder for the single-cycle RV32 core. It services the core's load/store request (write, load, address, store data, size) with byte-lane RAM and a small MMIO window. The MMIO window holds a console TX FIFO with a ready/valid output and a free-running cycle counter. Load data returns combinationally in the request cycle, because the core consumes it in the same cycle. Stores and all MMIO side effects commit on the rising clock edge.

Parameters:
MEM_WORDS, 4096, RAM depth in 32-bit words; must be a power of 2.
FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2 and at least 2.
MMIO_BASE, 32'hFFFF_0000, base of the MMIO window; the window is 16 bytes.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_write  in  1  store request this cycle
i_load  in  1  load request this cycle
i_addr  in  32  byte address
i_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
i_memsize  in  2  01 = byte, 10 = half, 11 = word, 00 = no store
o_rdata  out  32  load data, right-aligned, zero-filled above the access width; the core sign-extends
o_misalign  out  1  sticky misaligned-access flag
o_tx_data  out  8  FIFO head byte
o_tx_valid  out  1  FIFO non-empty
i_tx_ready  in  1  consumer accepts the head byte this cycle

Behaviour:
- Reset (asynchronous on i_rst_n low):
  - FIFO is empty; o_tx_valid = 0; o_tx_data = 0.
  - Cycle counter = 0; overflow flag = 0; o_misalign = 0.
  - RAM contents are not affected.
- Decode:
  - Any address in [MMIO_BASE, MMIO_BASE+15] is MMIO.
  - Every other address is RAM, indexed by i_addr[log2(MEM_WORDS)+1:2]. Higher address bits alias (wrap).
- Alignment:
  - A half access with addr[0]=1 is misaligned.
  - A word access with addr[1:0]≠0 is misaligned.
  - Byte accesses are always aligned.
  - A misaligned store is suppressed (no RAM or MMIO effect) and sets o_misalign on the next edge.
  - A misaligned load returns 0 and sets o_misalign.
  - o_misalign clears only on reset.
- RAM load:
  - o_rdata = (word >> 8*addr[1:0]), masked to the access width.
  - When i_memsize = 00 on a load, the access width is word.
  - When i_load = 0, o_rdata = 0.
- RAM store: on the clock edge, write only the byte lanes selected by size and addr[1:0], little-endian. Other lanes are unchanged.
- MMIO register map (offsets from MMIO_BASE):
  - +0 TXDATA: a store of any size pushes i_wdata[7:0]. Reads return 0.
  - +4 STATUS (read-only): bit0 = empty, bit1 = full, bit2 = overflow (sticky), bits[15:8] = occupancy count. Other bits are 0.
  - +8 CYCLE: increments by 1 every cycle and wraps at 2^32. A store of any size clears it to 0. When a store and an increment fall in the same cycle, the store wins (value 0 after the edge). Reads return the current value.
  - +12: reserved; reads return 0 and stores are ignored.
  - MMIO loads return the full 32-bit value regardless of size.
- TX FIFO:
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - A push to a full FIFO with no pop is dropped and sets overflow. Overflow clears only on reset.
  - A pop happens when o_tx_valid && i_tx_ready.
  - There is no bypass: a push into an empty FIFO raises o_tx_valid one cycle after the store edge.
  - On simultaneous push and pop, the count is unchanged and ordering is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_tx_data holds the head entry while valid, and is 0 when empty.
- Simultaneous i_write and i_load: treat the request as a store. o_rdata still reflects a load of the pre-edge contents.

Optional Feature:
- Macro: DMEM_BACKDOOR_EN.
- When defined, three ports are added: i_bd_we (1), i_bd_addr (log2(MEM_WORDS) word index), i_bd_data (32).
  - While i_bd_we is high, the full word is written on the clock edge.
  - The backdoor has priority over a CPU store to the same word in the same cycle; the CPU store to that word is dropped.
  - The backdoor does not touch MMIO or the flags.
- When not defined, these ports do not exist and RAM is writable only through the CPU interface.

Test Plan:
- Byte stores of 0x11, 0x22, 0x33, 0x44 to addresses 0x100–0x103, then a word load at 0x100 -> o_rdata = 0x44332211. A byte load at 0x102 -> 0x00000033.
- Word 0xAABBCCDD at 0x200, half store of 0x1234 at 0x202, half load at 0x202 -> 0x00001234. Word load at 0x200 -> 0x1234CCDD.
- Word store of 0xDEADBEEF at 0x301 -> RAM unchanged (word load at 0x300 returns its prior value), o_misalign = 1 after the edge, and it stays 1 after 10 further aligned accesses.
- With i_tx_ready = 0, push bytes 0..16 (17 stores) -> STATUS reads full = 1, count = 16, overflow = 1. Raise i_tx_ready -> o_tx_data streams 0x00..0x0F one per cycle, then o_tx_valid = 0 and empty = 1.
- FIFO holding 16 entries, i_tx_ready = 1, push 0x55 in the same cycle -> accepted, count stays 16, overflow stays 0, and 0x55 is the last byte out.
- After reset, wait 100 cycles and read CYCLE -> 100 (±0, per bench alignment). Store to +8, then read the next cycle -> 1. Pulse i_rst_n low mid-FIFO-drain -> o_tx_valid = 0 immediately and count = 0.
